// File: rtl/i2c_ctrl.sv
// Sequences one I2C register read/write into START/address/data/STOP byte commands for the bit engine.
// Latency: Go one cycle after acceptance and one cycle after each Trans_Done; RW_Done one cycle after the last step.
// Backpressure: one command in flight; waits for Trans_Done (or the timeout) before issuing the next; requests ignored while busy.
module i2c_ctrl #(
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        wrreg_req,
    input  logic        rdreg_req,
    input  logic [6:0]  device_id,
    input  logic [15:0] reg_addr,
    input  logic        addr_mode,
    input  logic [7:0]  wrdata,
    output logic [7:0]  rddata,
    output logic        busy,
    output logic        RW_Done,
    output logic        ack_err,
    output logic        timeout,
    output logic [5:0]  Cmd,
    output logic        Go,
    output logic [7:0]  Tx_DATA,
    input  logic [7:0]  Rx_DATA,
    input  logic        Trans_Done,
    input  logic        ack_o
);

    localparam logic [5:0]  C_WR   = 6'b000001;
    localparam logic [5:0]  C_STA  = 6'b000010;
    localparam logic [5:0]  C_RD   = 6'b000100;
    localparam logic [5:0]  C_STO  = 6'b001000;
    localparam logic [5:0]  C_NACK = 6'b100000;
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_is_rd, r_mode;
    logic [6:0]  r_dev;
    logic [15:0] r_addr;
    logic [7:0]  r_wdata;
    logic [2:0]  r_step;
    logic [19:0] r_cnt;
    logic        r_ack_err, r_timeout;
    logic [7:0]  r_rddata;

    logic        w_accept;
    logic [5:0]  w_step_cmd;
    logic [7:0]  w_step_dat;
    logic [2:0]  w_lo_idx, w_last_step;

    assign w_lo_idx    = r_mode ? 3'd2 : 3'd1;
    assign w_last_step = r_is_rd ? (w_lo_idx + 3'd2) : (w_lo_idx + 3'd1);

    // Step k is decoded from the latched request instead of storing a step list.
    always_comb begin
        w_step_cmd = 6'b0;
        w_step_dat = 8'h00;
        if (r_step == 3'd0) begin
            w_step_cmd = C_STA | C_WR;
            w_step_dat = {r_dev, 1'b0};
        end else if (r_mode && r_step == 3'd1) begin
            w_step_cmd = C_WR;
            w_step_dat = r_addr[15:8];
        end else if (r_step == w_lo_idx) begin
            w_step_cmd = C_WR;
            w_step_dat = r_addr[7:0];
        end else if (!r_is_rd) begin
            w_step_cmd = C_WR | C_STO;
            w_step_dat = r_wdata;
        end else if (r_step == w_lo_idx + 3'd1) begin
            w_step_cmd = C_STA | C_WR;
            w_step_dat = {r_dev, 1'b1};
        end else begin
            w_step_cmd = C_RD | C_NACK | C_STO;
            w_step_dat = 8'h00;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        Go       = 1'b0;
        busy     = 1'b0;
        RW_Done  = 1'b0;
        Cmd      = 6'b0;
        Tx_DATA  = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (wrreg_req || rdreg_req) begin
                    w_accept = 1'b1;
                    w_next   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                Go      = 1'b1;
                busy    = 1'b1;
                Cmd     = w_step_cmd;
                Tx_DATA = w_step_dat;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                busy    = 1'b1;
                Cmd     = w_step_cmd;
                Tx_DATA = w_step_dat;
                if (Trans_Done)
                    w_next = (r_step == w_last_step) ? S_DONE : S_ISSUE;
                else if (r_cnt == TO_LAST)
                    w_next = S_DONE;
            end
            S_DONE: begin
                RW_Done = 1'b1;
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_is_rd   <= 1'b0;
            r_mode    <= 1'b0;
            r_dev     <= 7'h00;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            r_step    <= 3'd0;
            r_cnt     <= 20'd0;
            r_ack_err <= 1'b0;
            r_timeout <= 1'b0;
            r_rddata  <= 8'h00;
        end else begin
            if (w_accept) begin
                r_is_rd   <= !wrreg_req;
                r_mode    <= addr_mode;
                r_dev     <= device_id;
                r_addr    <= reg_addr;
                r_wdata   <= wrdata;
                r_step    <= 3'd0;
                r_ack_err <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (r_state == S_ISSUE)
                r_cnt <= 20'd0;
            if (r_state == S_WAIT) begin
                if (Trans_Done) begin
                    if (w_step_cmd[0]) r_ack_err <= r_ack_err | ack_o;
                    if (w_step_cmd[2]) r_rddata  <= Rx_DATA;
                    r_step <= r_step + 3'd1;
                end else begin
                    r_cnt <= r_cnt + 20'd1;
                    if (r_cnt == TO_LAST) r_timeout <= 1'b1;
                end
            end
        end
    end

    assign rddata  = r_rddata;
    assign ack_err = r_ack_err;
    assign timeout = r_timeout;

endmodule
